x_counter_16_bit_checker: RTL and testbench
===========================================

# x_counter_16_bit_checker

Receive-side monitor for a free-running 16-bit up-counter whose value arrives as sixteen individual single-bit nets. It samples the bits every clock and checks that each sample equals the previous sample plus one, modulo 2^16. It acquires lock after a run of consecutive good increments, reports wrap-around, and flags and counts sequence errors. It sits at the board/IP boundary as the consumer end of a counter link and drives status nets for LEDs or test points.

## Interface
- LOCK_COUNT, 4: consecutive good increments required to enter LOCKED; legal range 1..15.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_count_15 .. i_count_0  in  1 each  counter value bits, MSB i_count_15; synchronous to i_clk.
- o_locked  out  1  high while state is LOCKED.
- o_error  out  1  one-cycle pulse on a sequence error detected while LOCKED.
- o_wrap  out  1  one-cycle pulse on a good 0xFFFF -> 0x0000 step while LOCKED.
- o_err_count_3 .. o_err_count_0  out  1 each  saturating 4-bit error count, MSB o_err_count_3.

## Operation
- Internal registers:
  - in_q[15:0]: the current sample.
  - prev_q[15:0]: the previous sample.
  - state: EMPTY, PRIME, SYNC or LOCKED.
  - good_q[3:0]: count of consecutive good increments.
  - err_q[3:0]: error count.
  - Registered outputs error_q and wrap_q.
- Every edge out of reset: in_q <= {i_count_15..i_count_0} and prev_q <= in_q.
- match = (in_q == prev_q + 16'd1), computed 16-bit and truncated, so 0xFFFF -> 0x0000 is a match. match is only evaluated in SYNC and LOCKED.
- Reset values: every register and output is 0, and state = EMPTY. The outputs are therefore o_locked=0, o_error=0, o_wrap=0 and o_err_count=0.
- EMPTY: next edge -> PRIME, because in_q now holds the first sample.
- PRIME: next edge -> SYNC with good_q=0, because prev_q is now valid.
- SYNC:
  - On match: good_q+1. If good_q+1 == LOCK_COUNT, go to LOCKED and clear good_q.
  - On mismatch: good_q=0 and stay in SYNC. No error pulse and no err_q change.
- LOCKED:
  - On match: stay in LOCKED. If additionally in_q == 0x0000, then wrap_q=1 for one cycle.
  - On mismatch: go to SYNC with good_q=0, set error_q=1 for one cycle, and increment err_q, saturating at 15.
- Error and wrap are mutually exclusive. A mismatch whose in_q is 0x0000 gives error only.
- A wrap seen in SYNC, including on the edge that enters LOCKED, does not pulse o_wrap.
- After an error, re-lock needs LOCK_COUNT further good increments. The error count err_q persists until reset.
- o_locked is driven directly from the state register. o_error, o_wrap and o_err_count come from registers; no combinational path runs from input to output.
- Reset asserted mid-operation clears everything immediately. This includes err_q and any pulse in flight. Acquisition restarts from EMPTY.

## Timing
- Edge numbering: edge 1 is the first rising edge after i_rst_n deasserts.
- Edge 1 goes EMPTY -> PRIME; edge 2 goes PRIME -> SYNC; edges 3.. evaluate match.
- Minimum lock latency: o_locked rises after edge 2+LOCK_COUNT, which is edge 6 for the default LOCK_COUNT=4.
- Detection latency: a bad value on the inputs before edge n is captured into in_q at edge n. It is compared, and o_error/o_locked update, at edge n+1. o_error is high for exactly the cycle following edge n+1.
- Wrap latency: 0x0000 captured at edge n gives o_wrap high for the cycle after edge n+1.
- o_err_count updates on the same edge as the o_error pulse.
- Throughput: one sample checked per clock with no bubbles.

## Test plan
- Drive the inputs from a reset-synchronised 16-bit up-counter (0,1,2,...) with LOCK_COUNT=4 -> o_locked=0 through edge 5, o_locked=1 after edge 6, and o_error never pulses.
- Run while locked until the counter passes 0xFFFF -> 0x0000 -> exactly one o_wrap pulse, in the cycle after 0x0000 is compared; o_locked stays 1 and o_err_count stays 0.
- Once locked, force i_count_3 stuck at 0 for one sample (e.g. 0x0108 presented as 0x0100) -> one o_error pulse, o_locked drops, and o_err_count=1. That sample and the following one both mismatch; the mismatch in SYNC is not counted. Re-lock follows after 4 good increments.
- Hold the inputs constant at 0x1234 -> never locks, o_error never pulses, o_err_count stays 0.
- Cause 20 separate errors, each followed by re-lock -> o_err_count saturates at 15 (all bits 1) and o_error still pulses 20 times.
- Assert i_rst_n low mid-lock with o_err_count=3 -> all outputs go to 0 immediately, asynchronously; after release, lock is re-acquired at edge 6.

Source files
------------

// File: rtl/x_counter_16_bit_checker.sv
// x_counter_16_bit_checker
//   Receive-side monitor for a free-running 16-bit up-counter delivered as
//   sixteen single-bit nets. Each clock the bits are sampled. Every sample
//   must equal the previous sample plus one, modulo 2^16.
//   Lock is acquired after LOCK_COUNT consecutive good increments. Wrap is
//   reported while locked. Sequence errors seen while locked are flagged
//   and counted.
//
// Ports
//   i_clk                        clock, rising edge
//   i_rst_n                      async reset, active low
//   i_count_15 .. i_count_0      counter bits, MSB first
//   o_locked                     high while LOCKED
//   o_error                      one-cycle pulse on a mismatch while LOCKED
//   o_wrap                       one-cycle pulse on a good FFFF->0000 step while LOCKED
//   o_err_count_3 .. _0          saturating 4-bit error count
module x_counter_16_bit_checker #(
  parameter int unsigned LOCK_COUNT = 4   // legal 1..15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_count_15,
  input  logic i_count_14,
  input  logic i_count_13,
  input  logic i_count_12,
  input  logic i_count_11,
  input  logic i_count_10,
  input  logic i_count_9,
  input  logic i_count_8,
  input  logic i_count_7,
  input  logic i_count_6,
  input  logic i_count_5,
  input  logic i_count_4,
  input  logic i_count_3,
  input  logic i_count_2,
  input  logic i_count_1,
  input  logic i_count_0,
  output logic o_locked,
  output logic o_error,
  output logic o_wrap,
  output logic o_err_count_3,
  output logic o_err_count_2,
  output logic o_err_count_1,
  output logic o_err_count_0
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_PRIME  = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  logic [15:0] cnt_w;
  logic [15:0] in_q, prev_q;
  logic [1:0]  state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  err_q, err_d;
  logic        error_q, error_d;
  logic        wrap_q, wrap_d;
  logic [15:0] prev_inc;
  logic [3:0]  good_inc;
  logic        match;

  assign cnt_w = {i_count_15, i_count_14, i_count_13, i_count_12,
                  i_count_11, i_count_10, i_count_9,  i_count_8,
                  i_count_7,  i_count_6,  i_count_5,  i_count_4,
                  i_count_3,  i_count_2,  i_count_1,  i_count_0};

  // 16-bit truncating add, so FFFF followed by 0000 counts as a match.
  assign prev_inc = prev_q + 16'd1;
  assign match    = (in_q == prev_inc);
  assign good_inc = good_q + 4'd1;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = err_q;
    error_d = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      ST_EMPTY: state_d = ST_PRIME;   // in_q now holds the first sample
      ST_PRIME: begin                 // prev_q becomes valid on this edge
        state_d = ST_SYNC;
        good_d  = 4'd0;
      end
      ST_SYNC: begin
        // Wraps seen here, including on the lock-entry edge, are not reported.
        if (match) begin
          if (good_inc == LOCK_N) begin
            state_d = ST_LOCKED;
            good_d  = 4'd0;
          end else begin
            good_d  = good_inc;
          end
        end else begin
          good_d = 4'd0;
        end
      end
      default: begin                  // ST_LOCKED
        if (match) begin
          wrap_d = (in_q == 16'h0000);
        end else begin
          state_d = ST_SYNC;
          good_d  = 4'd0;
          error_d = 1'b1;
          if (err_q != 4'hF) err_d = err_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_q    <= '0;
      prev_q  <= '0;
      state_q <= ST_EMPTY;
      good_q  <= '0;
      err_q   <= '0;
      error_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      in_q    <= cnt_w;
      prev_q  <= in_q;
      state_q <= state_d;
      good_q  <= good_d;
      err_q   <= err_d;
      error_q <= error_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_locked      = (state_q == ST_LOCKED);
  assign o_error       = error_q;
  assign o_wrap        = wrap_q;
  assign o_err_count_3 = err_q[3];
  assign o_err_count_2 = err_q[2];
  assign o_err_count_1 = err_q[1];
  assign o_err_count_0 = err_q[0];

endmodule

// File: tb/tb_x_counter_16_bit_checker.sv
// Bench for x_counter_16_bit_checker. The reference model tracks the
// counter history as plain integers. It keeps the length of the current
// streak of good increments. The checker is locked exactly when that streak
// has reached LOCK_COUNT. An error is a broken streak that was at or past
// LOCK_COUNT. A wrap is a good step onto zero while already locked.
module tb_x_counter_16_bit_checker;
  localparam int L = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [15:0] cnt_in;
  logic        o_locked, o_error, o_wrap;
  logic [3:0]  ec;

  x_counter_16_bit_checker #(.LOCK_COUNT(L)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_count_15(cnt_in[15]), .i_count_14(cnt_in[14]), .i_count_13(cnt_in[13]),
    .i_count_12(cnt_in[12]), .i_count_11(cnt_in[11]), .i_count_10(cnt_in[10]),
    .i_count_9(cnt_in[9]),   .i_count_8(cnt_in[8]),   .i_count_7(cnt_in[7]),
    .i_count_6(cnt_in[6]),   .i_count_5(cnt_in[5]),   .i_count_4(cnt_in[4]),
    .i_count_3(cnt_in[3]),   .i_count_2(cnt_in[2]),   .i_count_1(cnt_in[1]),
    .i_count_0(cnt_in[0]),
    .o_locked(o_locked), .o_error(o_error), .o_wrap(o_wrap),
    .o_err_count_3(ec[3]), .o_err_count_2(ec[2]),
    .o_err_count_1(ec[1]), .o_err_count_0(ec[0])
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int edge_n, cur_m, prv_m, streak, errs_m;
  logic exp_locked, exp_err, exp_wrap;
  int obs_err_pulses, obs_wrap_pulses;
  int cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    edge_n = 0; cur_m = 0; prv_m = 0; streak = 0; errs_m = 0;
    exp_locked = 1'b0; exp_err = 1'b0; exp_wrap = 1'b0;
  endtask

  // Present v for one edge, advance the model, then check all outputs.
  task automatic tick(input int v);
    bit good, was_locked;
    cnt_in = 16'(v);
    @(posedge i_clk);
    edge_n++;
    exp_err  = 1'b0;
    exp_wrap = 1'b0;
    if (edge_n >= 3) begin
      good       = (cur_m == ((prv_m + 1) % 65536));
      was_locked = (streak >= L);
      if (good) begin
        if (streak < 1000) streak++;
        if (was_locked && cur_m == 0) exp_wrap = 1'b1;
      end else begin
        if (was_locked) begin
          exp_err = 1'b1;
          errs_m++;
        end
        streak = 0;
      end
    end
    prv_m = cur_m;
    cur_m = v & 16'hFFFF;
    exp_locked = (streak >= L);
    #1;
    if (o_error === 1'b1) obs_err_pulses++;
    if (o_wrap === 1'b1)  obs_wrap_pulses++;
    chk("locked", 16'(o_locked), 16'(exp_locked));
    chk("error",  16'(o_error),  16'(exp_err));
    chk("wrap",   16'(o_wrap),   16'(exp_wrap));
    chk("errcnt", 16'(ec),       16'((errs_m > 15) ? 15 : errs_m));
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #3;
    chk("rst_locked", 16'(o_locked), 16'd0);
    chk("rst_errcnt", 16'(ec), 16'd0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    int base;
    i_rst_n = 1'b0;
    cnt_in  = '0;
    obs_err_pulses = 0;
    obs_wrap_pulses = 0;
    model_reset();
    #12;
    chk("init_locked", 16'(o_locked), 16'd0);
    chk("init_error",  16'(o_error),  16'd0);
    chk("init_wrap",   16'(o_wrap),   16'd0);
    chk("init_errcnt", 16'(ec),       16'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // A: up-counter from 0, lock exactly after edge 6
    cnt = 0;
    repeat (5) begin tick(cnt); cnt++; end
    chk("lock_edge5", 16'(o_locked), 16'd0);
    tick(cnt); cnt++;
    chk("lock_edge6", 16'(o_locked), 16'd1);
    repeat (6) begin tick(cnt); cnt++; end
    chk("A_err_pulses", 16'(obs_err_pulses), 16'd0);

    // B: run through FFFF -> 0000 while locked
    do_reset();
    cnt = 16'hFFF0;
    base = obs_wrap_pulses;
    repeat (28) begin tick(cnt & 16'hFFFF); cnt++; end
    chk("B_wrap_pulses", 16'(obs_wrap_pulses - base), 16'd1);
    chk("B_locked", 16'(o_locked), 16'd1);
    chk("B_errcnt", 16'(ec), 16'd0);

    // C: i_count_3 stuck at 0 for one sample, then re-lock
    while ((cnt & 8) == 0) begin tick(cnt & 16'hFFFF); cnt++; end
    base = obs_err_pulses;
    tick((cnt & 16'hFFFF) & ~8); cnt++;
    tick(cnt & 16'hFFFF); cnt++;
    chk("C_unlocked", 16'(o_locked), 16'd0);
    chk("C_errcnt", 16'(ec), 16'd1);
    repeat (5) begin tick(cnt & 16'hFFFF); cnt++; end
    chk("C_relock", 16'(o_locked), 16'd1);
    chk("C_err_pulses", 16'(obs_err_pulses - base), 16'd1);

    // D: constant input never locks
    do_reset();
    base = obs_err_pulses;
    repeat (30) tick(16'h1234);
    chk("D_locked", 16'(o_locked), 16'd0);
    chk("D_errcnt", 16'(ec), 16'd0);
    chk("D_err_pulses", 16'(obs_err_pulses - base), 16'd0);

    // E: 20 errors each followed by re-lock -> saturation
    do_reset();
    cnt = int'($urandom_range(0, 65535));
    base = obs_err_pulses;
    repeat (8) begin tick(cnt & 16'hFFFF); cnt++; end
    repeat (20) begin
      tick((cnt ^ int'($urandom_range(1, 65535))) & 16'hFFFF); cnt++;
      repeat (7) begin tick(cnt & 16'hFFFF); cnt++; end
    end
    chk("E_errcnt_sat", 16'(ec), 16'd15);
    chk("E_err_pulses", 16'(obs_err_pulses - base), 16'd20);

    // F: three errors, then asynchronous reset mid-lock
    do_reset();
    cnt = int'($urandom_range(0, 65535));
    repeat (8) begin tick(cnt & 16'hFFFF); cnt++; end
    repeat (3) begin
      tick((cnt ^ int'($urandom_range(1, 65535))) & 16'hFFFF); cnt++;
      repeat (7) begin tick(cnt & 16'hFFFF); cnt++; end
    end
    chk("F_errcnt3", 16'(ec), 16'd3);
    chk("F_locked", 16'(o_locked), 16'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("F_async_locked", 16'(o_locked), 16'd0);
    chk("F_async_error",  16'(o_error),  16'd0);
    chk("F_async_wrap",   16'(o_wrap),   16'd0);
    chk("F_async_errcnt", 16'(ec),       16'd0);
    model_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cnt = 0;
    repeat (5) begin tick(cnt); cnt++; end
    chk("F_relock_edge5", 16'(o_locked), 16'd0);
    tick(cnt); cnt++;
    chk("F_relock_edge6", 16'(o_locked), 16'd1);

    // G: random traffic with sporadic corruptions and stalls
    do_reset();
    cnt = int'($urandom_range(0, 65535));
    repeat (400) begin
      case ($urandom_range(0, 11))
        0:       tick((cnt ^ int'($urandom_range(1, 65535))) & 16'hFFFF);
        1:       begin cnt--; tick(cnt & 16'hFFFF); end
        default: tick(cnt & 16'hFFFF);
      endcase
      cnt++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
